// File: rtl/chunked_adder_pkg.sv
// adder_pkg: shared types and helpers for the chunked add/subtract unit.
//   add_state_t : control states of chunked_adder
//   idx_width() : width of the slice index counter, never less than one bit
package adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } add_state_t;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/chunked_adder_cpa_chunk.sv
// cpa_chunk: combinational W-bit carry-propagate adder slice.
//   a, b : W-bit addends
//   cin  : carry into bit 0
//   s    : W-bit sum
//   cout : carry out of bit W-1
module cpa_chunk #(
  parameter int W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] s,
  output logic         cout
);

  assign {cout, s} = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};

endmodule

// File: rtl/chunked_adder.sv
// chunked_adder: multi-cycle WIDTH-bit add/subtract. One CHUNK-bit slice is
// added per clock through a single shared cpa_chunk, so an operation spends
// WIDTH/CHUNK clocks in BUSY.
//   clk, rst_n           : clock, asynchronous active-low reset
//   in_valid / in_ready  : operand handshake (a, b, cin, sub)
//   out_valid / out_ready: result handshake (s, cout, ovf)
//   sub=0: s = a + b + cin    sub=1: s = a - b - cin (cout=1 means no borrow)
//   ovf                  : two's-complement signed overflow
//
// state | meaning
// IDLE  | waiting for operands, in_ready=1
// BUSY  | rippling the carry through one slice per clock
// DONE  | result held on s/cout/ovf until out_ready
module chunked_adder #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf
);
  import adder_pkg::*;

  localparam int CHUNK_SAFE = (CHUNK < 1) ? 1 : CHUNK;
  localparam int NCHUNK     = WIDTH / CHUNK_SAFE;
  localparam int IDXW       = idx_width(NCHUNK);
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCHUNK - 1);

  generate
    if (CHUNK < 1 || (WIDTH % CHUNK_SAFE) != 0) begin : g_bad_params
      $error("chunked_adder: WIDTH must be a positive multiple of CHUNK");
    end
  endgenerate

  add_state_t state, state_nxt;

  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;      // already inverted for subtract
  logic             c_q;      // running slice carry
  logic [IDXW-1:0]  idx;
  logic [WIDTH-1:0] s_q;
  logic             cout_q;
  logic             ovf_q;

  logic             accept;
  logic             last;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [CHUNK-1:0] sl_s;
  logic             sl_cout;

  // Slice selection by shifting the active slice down to bit 0.
  assign a_sh = a_q >> (int'(idx) * CHUNK);
  assign b_sh = b_q >> (int'(idx) * CHUNK);

  cpa_chunk #(.W(CHUNK)) u_slice (
    .a    (a_sh[CHUNK-1:0]),
    .b    (b_sh[CHUNK-1:0]),
    .cin  (c_q),
    .s    (sl_s),
    .cout (sl_cout)
  );

  assign accept = in_valid && in_ready;
  assign last   = (idx == LAST_IDX);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept)    state_nxt = BUSY;
      BUSY:    if (last)      state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE:    in_ready  = 1'b1;
      DONE:    out_valid = 1'b1;
      default: ;
    endcase
  end

  // Datapath: operand capture, per-slice accumulation and flag generation
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q    <= '0;
      b_q    <= '0;
      c_q    <= 1'b0;
      idx    <= '0;
      s_q    <= '0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            // a - b - cin == a + ~b + ~cin modulo 2^WIDTH
            a_q <= a;
            b_q <= sub ? ~b : b;
            c_q <= sub ? ~cin : cin;
            idx <= '0;
          end
        end
        BUSY: begin
          s_q[int'(idx)*CHUNK +: CHUNK] <= sl_s;
          c_q <= sl_cout;
          idx <= idx + 1'b1;
          if (last) begin
            cout_q <= sl_cout;
            // sl_s carries the final MSB this cycle; s_q does not have it yet
            ovf_q  <= (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                      (sl_s[CHUNK-1] != a_q[WIDTH-1]);
          end
        end
        default: ;
      endcase
    end
  end

  assign s    = s_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_chunked_adder.sv
module tb_chunked_adder;

  logic clk;
  logic rst_n;

  // index 0: WIDTH=16 CHUNK=4, index 1: WIDTH=16 CHUNK=16
  logic        in_valid [2];
  logic        in_ready [2];
  logic [15:0] a        [2];
  logic [15:0] b        [2];
  logic        cin      [2];
  logic        sub      [2];
  logic        out_valid[2];
  logic        out_ready[2];
  logic [15:0] s        [2];
  logic        cout     [2];
  logic        ovf      [2];

  int total;
  int bad;

  chunked_adder #(.WIDTH(16), .CHUNK(4)) dut4 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .a(a[0]), .b(b[0]), .cin(cin[0]), .sub(sub[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .s(s[0]), .cout(cout[0]), .ovf(ovf[0])
  );

  chunked_adder #(.WIDTH(16), .CHUNK(16)) dut16 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .a(a[1]), .b(b[1]), .cin(cin[1]), .sub(sub[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .s(s[1]), .cout(cout[1]), .ovf(ovf[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference: plain integer arithmetic on unsigned and signed views.
  function automatic void model(input logic [15:0] x, input logic [15:0] y,
                                input logic ci, input logic sb,
                                output logic [15:0] rs, output logic rc,
                                output logic ro);
    int ux, uy, sx, sy, r, sr;
    ux = int'(x);
    uy = int'(y);
    sx = int'($signed(x));
    sy = int'($signed(y));
    if (!sb) begin
      r  = ux + uy + int'(ci);
      sr = sx + sy + int'(ci);
      rc = (r > 65535);
    end else begin
      r  = ux - uy - int'(ci);
      sr = sx - sy - int'(ci);
      rc = (r >= 0);
    end
    rs = 16'(r);
    ro = (sr > 32767) || (sr < -32768);
  endfunction

  task automatic do_op(input int k, input logic [15:0] ai, input logic [15:0] bi,
                       input logic ci, input logic si,
                       output logic [15:0] so, output logic co, output logic oo,
                       output int lat);
    int w;
    w = 0;
    @(negedge clk);
    while (!in_ready[k] && w < 20) begin
      @(negedge clk);
      w++;
    end
    a[k] = ai; b[k] = bi; cin[k] = ci; sub[k] = si;
    in_valid[k] = 1'b1;
    out_ready[k] = 1'b0;
    @(posedge clk);
    #1;
    in_valid[k] = 1'b0;
    lat = 0;
    while (!out_valid[k] && lat < 50) begin
      @(posedge clk);
      #1;
      lat++;
    end
    so = s[k]; co = cout[k]; oo = ovf[k];
  endtask

  task automatic finish_op(input int k);
    @(negedge clk);
    out_ready[k] = 1'b1;
    @(posedge clk);
    #1;
    out_ready[k] = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      total++;
      if (in_ready[k] !== 1'b1 || out_valid[k] !== 1'b0 || s[k] !== 16'h0 ||
          cout[k] !== 1'b0 || ovf[k] !== 1'b0) begin
        bad++;
        $display("FAIL reset dut%0d: in_ready=%b out_valid=%b s=%h cout=%b ovf=%b required 1 0 0000 0 0",
                 k, in_ready[k], out_valid[k], s[k], cout[k], ovf[k]);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    total++;
    if (in_ready[0] !== 1'b1 || out_valid[0] !== 1'b0) begin
      bad++;
      $display("FAIL post_reset: in_ready=%b out_valid=%b required 1 0", in_ready[0], out_valid[0]);
    end
  endtask

  task automatic test_directed;
    logic [15:0] ta [5] = '{16'h0006, 16'hFFFF, 16'h7FFF, 16'd12, 16'd3};
    logic [15:0] tb [5] = '{16'h0003, 16'h0001, 16'h0001, 16'd5,  16'd5};
    logic        tc [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    logic        tsb[5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [15:0] es [5] = '{16'h0009, 16'h0000, 16'h8000, 16'h0007, 16'hFFFD};
    logic        ec [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    logic        eo [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    logic [15:0] rs;
    logic        rc, ro;
    int          lat;
    for (int i = 0; i < 5; i++) begin
      do_op(0, ta[i], tb[i], tc[i], tsb[i], rs, rc, ro, lat);
      total++;
      if (rs !== es[i] || rc !== ec[i] || ro !== eo[i]) begin
        bad++;
        $display("FAIL directed[%0d]: s=%h cout=%b ovf=%b required s=%h cout=%b ovf=%b",
                 i, rs, rc, ro, es[i], ec[i], eo[i]);
      end
      total++;
      if (lat != 4) begin
        bad++;
        $display("FAIL directed_latency[%0d]: got %0d clocks required 4", i, lat);
      end
      finish_op(0);
      total++;
      if (out_valid[0] !== 1'b0 || in_ready[0] !== 1'b1) begin
        bad++;
        $display("FAIL directed_release[%0d]: out_valid=%b in_ready=%b required 0 1",
                 i, out_valid[0], in_ready[0]);
      end
    end
  endtask

  task automatic test_backpressure;
    logic [15:0] rs, es;
    logic        rc, ro, ec, eo;
    int          lat;
    model(16'h7A35, 16'h1C4B, 1'b1, 1'b0, es, ec, eo);
    do_op(0, 16'h7A35, 16'h1C4B, 1'b1, 1'b0, rs, rc, ro, lat);
    total++;
    if (rs !== es || rc !== ec || ro !== eo) begin
      bad++;
      $display("FAIL bp_result: s=%h cout=%b ovf=%b required %h %b %b", rs, rc, ro, es, ec, eo);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid[0] = i[0];
      a[0] = 16'($urandom);
      b[0] = 16'($urandom);
      @(posedge clk);
      #1;
      total++;
      if (out_valid[0] !== 1'b1 || in_ready[0] !== 1'b0 || s[0] !== es ||
          cout[0] !== ec || ovf[0] !== eo) begin
        bad++;
        $display("FAIL bp_hold[%0d]: out_valid=%b in_ready=%b s=%h cout=%b ovf=%b required 1 0 %h %b %b",
                 i, out_valid[0], in_ready[0], s[0], cout[0], ovf[0], es, ec, eo);
      end
    end
    // release together with a pending request: must return to IDLE, not start
    @(negedge clk);
    in_valid[0] = 1'b1;
    out_ready[0] = 1'b1;
    @(posedge clk);
    #1;
    in_valid[0] = 1'b0;
    out_ready[0] = 1'b0;
    total++;
    if (out_valid[0] !== 1'b0 || in_ready[0] !== 1'b1) begin
      bad++;
      $display("FAIL bp_release: out_valid=%b in_ready=%b required 0 1", out_valid[0], in_ready[0]);
    end
  endtask

  task automatic test_reset_busy;
    logic [15:0] rs;
    logic        rc, ro;
    int          lat;
    @(negedge clk);
    a[0] = 16'h00FF; b[0] = 16'h0F0F; cin[0] = 1'b1; sub[0] = 1'b0;
    in_valid[0] = 1'b1;
    @(posedge clk);
    #1;
    in_valid[0] = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    total++;
    if (out_valid[0] !== 1'b0 || s[0] !== 16'h0 || in_ready[0] !== 1'b1 || cout[0] !== 1'b0) begin
      bad++;
      $display("FAIL reset_busy: out_valid=%b s=%h in_ready=%b cout=%b required 0 0000 1 0",
               out_valid[0], s[0], in_ready[0], cout[0]);
    end
    @(negedge clk);
    rst_n = 1'b1;
    do_op(0, 16'h0006, 16'h0003, 1'b0, 1'b0, rs, rc, ro, lat);
    total++;
    if (rs !== 16'h0009 || rc !== 1'b0 || ro !== 1'b0 || lat != 4) begin
      bad++;
      $display("FAIL reset_busy_recover: s=%h cout=%b ovf=%b lat=%0d required 0009 0 0 4", rs, rc, ro, lat);
    end
    finish_op(0);
  endtask

  task automatic test_single_slice;
    logic [15:0] rs;
    logic        rc, ro;
    int          lat;
    do_op(1, 16'd12, 16'd3, 1'b0, 1'b0, rs, rc, ro, lat);
    total++;
    if (rs !== 16'd15 || rc !== 1'b0 || ro !== 1'b0 || lat != 1) begin
      bad++;
      $display("FAIL single_slice: s=%h cout=%b ovf=%b lat=%0d required 000f 0 0 1", rs, rc, ro, lat);
    end
    finish_op(1);
  endtask

  function automatic logic [15:0] pick_operand();
    logic [15:0] corner [4] = '{16'h0000, 16'hFFFF, 16'h8000, 16'h7FFF};
    if ($urandom_range(0, 3) == 0) return corner[$urandom_range(0, 3)];
    return 16'($urandom);
  endfunction

  task automatic test_random(input int k, input int n, input int exp_lat);
    logic [15:0] ai, bi, rs, es;
    logic        ci, si, rc, ro, ec, eo;
    int          lat;
    for (int i = 0; i < n; i++) begin
      ai = pick_operand();
      bi = pick_operand();
      ci = 1'($urandom);
      si = 1'($urandom);
      model(ai, bi, ci, si, es, ec, eo);
      do_op(k, ai, bi, ci, si, rs, rc, ro, lat);
      total++;
      if (rs !== es || rc !== ec || ro !== eo || lat != exp_lat) begin
        bad++;
        $display("FAIL random dut%0d[%0d] a=%h b=%h cin=%b sub=%b: s=%h cout=%b ovf=%b lat=%0d required %h %b %b %0d",
                 k, i, ai, bi, ci, si, rs, rc, ro, lat, es, ec, eo, exp_lat);
      end
      finish_op(k);
    end
  endtask

  // Held-high handshakes: accepts every NCHUNK+2 clocks, results in order.
  task automatic test_back_to_back;
    logic [15:0] qs [$];
    logic        qc [$];
    logic        qo [$];
    logic [15:0] es;
    logic        ec, eo, need_new;
    int          prev, accepted;
    prev = -1;
    accepted = 0;
    need_new = 1'b0;
    @(negedge clk);
    a[0] = 16'($urandom); b[0] = 16'($urandom);
    cin[0] = 1'($urandom); sub[0] = 1'($urandom);
    in_valid[0] = 1'b1;
    out_ready[0] = 1'b1;
    for (int cyc = 0; cyc < 100; cyc++) begin
      if (need_new) begin
        need_new = 1'b0;
        if (accepted == 5) in_valid[0] = 1'b0;
        else begin
          a[0] = 16'($urandom); b[0] = 16'($urandom);
          cin[0] = 1'($urandom); sub[0] = 1'($urandom);
        end
      end
      if (out_valid[0]) begin
        total++;
        if (qs.size() == 0) begin
          bad++;
          $display("FAIL b2b_extra: out_valid=1 with no outstanding operation");
        end else begin
          es = qs.pop_front(); ec = qc.pop_front(); eo = qo.pop_front();
          if (s[0] !== es || cout[0] !== ec || ovf[0] !== eo) begin
            bad++;
            $display("FAIL b2b_result: s=%h cout=%b ovf=%b required %h %b %b",
                     s[0], cout[0], ovf[0], es, ec, eo);
          end
        end
      end
      if (in_ready[0] && in_valid[0]) begin
        if (prev >= 0) begin
          total++;
          if (cyc - prev != 6) begin
            bad++;
            $display("FAIL b2b_spacing: %0d clocks between accepts required 6", cyc - prev);
          end
        end
        prev = cyc;
        model(a[0], b[0], cin[0], sub[0], es, ec, eo);
        qs.push_back(es); qc.push_back(ec); qo.push_back(eo);
        accepted++;
        need_new = 1'b1;
      end
      if (accepted == 5 && qs.size() == 0) break;
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    in_valid[0] = 1'b0;
    out_ready[0] = 1'b0;
    total++;
    if (accepted != 5 || qs.size() != 0 || in_ready[0] !== 1'b1) begin
      bad++;
      $display("FAIL b2b_drain: accepted=%0d outstanding=%0d in_ready=%b required 5 0 1",
               accepted, qs.size(), in_ready[0]);
    end
  endtask

  initial begin
    total = 0;
    bad = 0;
    rst_n = 1'b0;
    for (int k = 0; k < 2; k++) begin
      in_valid[k] = 1'b0; out_ready[k] = 1'b0;
      a[k] = '0; b[k] = '0; cin[k] = 1'b0; sub[k] = 1'b0;
    end
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_busy();
    test_single_slice();
    test_random(1, 1000, 1);
    test_random(0, 200, 4);
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
